axis_blk_header_rx: RTL and testbench
=====================================

# axis_blk_header_rx

AXI4-Stream slave that deserializes one 80-byte Bitcoin block header (20 × 32-bit beats) into the miner's parallel header fields. It sits directly upstream of the miner core inside the test IP. It presents a complete header with a valid/ready handshake and back-pressures the stream while the miner has not taken the header. Frame length is checked against `s_axis_tlast`, and malformed frames are discarded.

## Interface
Parameters:
- `C_S_AXIS_TDATA_WIDTH`, 32: stream data width; only 32 is supported, and elaboration fails otherwise.
- `LAST_CHECK`, 1: when 1, `tlast` framing is enforced; when 0, `tlast` is ignored and every 20 beats form a header.

Ports:
- `aclk` in 1: the single clock; all logic is on its rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 32: header word.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tready` out 1: beat accept.
- `s_axis_tlast` in 1: last beat of frame.
- `blk_version` out 32: header word 0.
- `prev_blk_header_hash` out 256: words 1..8.
- `merkle_root_hash` out 256: words 9..16.
- `blk_time` out 32: word 17.
- `blk_nbits` out 32: word 18.
- `blk_nonce` out 32: word 19.
- `hdr_valid` out 1: header fields complete and stable.
- `hdr_ready` in 1: miner takes the header (the miner's `start`).
- `frame_err` out 1: one-cycle pulse on a framing violation.

## Operation
- A beat is accepted when `s_axis_tvalid && s_axis_tready`.
- A 5-bit word counter `wcnt` runs 0..19 and selects the destination field.
- Multi-word fields are filled MSB-first. In `prev_blk_header_hash`, word 1 goes to [255:224] and word 8 to [31:0]. `merkle_root_hash` follows the same rule.
- Beat data is stored unmodified; no byte swapping is done.
- The state machine has three states: COLLECT, HOLD, DISCARD.
- COLLECT:
  - `tready`=1.
  - Accepted beat with `wcnt`<19 and `tlast`=1 (when `LAST_CHECK`): `frame_err` pulses, `wcnt`←0, state stays COLLECT.
  - Accepted beat with `wcnt`=19 and `tlast`=1 (or `LAST_CHECK`=0): go to HOLD.
  - Accepted beat with `wcnt`=19 and `tlast`=0 (when `LAST_CHECK`): `frame_err` pulses, fields are not presented, go to DISCARD.
- HOLD:
  - `tready`=0 and `hdr_valid`=1. Field outputs are frozen.
  - On `hdr_ready`=1: `wcnt`←0, go to COLLECT.
- DISCARD:
  - `tready`=1. Beats are dropped.
  - An accepted beat with `tlast`=1 returns to COLLECT with `wcnt`=0.
- In COLLECT, field outputs are undefined for consumers and may change; only `hdr_valid` qualifies them.
- Reset values: `s_axis_tready`=0 while `aresetn`=0, then 1 from the first clock after release. `hdr_valid`=0, `frame_err`=0, all fields 0, `wcnt`=0, state COLLECT.
- Reset mid-frame drops the partial frame. The next accepted beat is word 0.

## Timing
- `hdr_valid` rises in the cycle after the clock edge that accepts word 19. Latency from the last beat is 1 cycle.
- `s_axis_tready` falls in that same cycle. No beat is accepted while `hdr_valid`=1.
- The `hdr_valid && hdr_ready` handshake completes at a clock edge. Next cycle: `hdr_valid`=0 and `tready`=1.
- Header-to-header throughput is 20 beats plus 1 HOLD cycle minimum.
- `hdr_ready` asserted outside HOLD is ignored.
- `frame_err` is registered. It is high for exactly the one cycle after the offending beat edge.
- `tvalid` gaps of any length are tolerated. `wcnt` advances only on accepted beats.
- `tdata` and `tlast` are sampled only on accepted beats.

## Structure
- Shared package `miner_pkg` holds:
  - `HDR_WORDS`=20.
  - Word-index constants `IDX_VERSION`=0, `IDX_PREV`=1, `IDX_MERKLE`=9, `IDX_TIME`=17, `IDX_NBITS`=18, `IDX_NONCE`=19.
  - A state enum `hdr_rx_state_t`.
- Field storage is one 640-bit register written by word index, with the fields sliced from it.
- No sub-module is needed; the block is a single module.

## Test plan
- Nominal frame, `hdr_ready` tied 1:
  - Stimulus: `blk_version`=0x02000000, `prev_blk_header_hash`=0x671D0E2F…0000, `merkle_root_hash`=0x2CD900FC…45F4992E, `blk_time`=0x74749054, `blk_nbits`=0x747B1B18, `blk_nonce`=0x43F740C0, `tlast` on beat 20.
  - Response: `hdr_valid` for 1 cycle, starting 1 cycle after beat 20, with all fields exact and `frame_err` never set.
- Back-pressure: hold `hdr_ready`=0 for 10 cycles after `hdr_valid`, with a second frame pending.
  - Response: `tready`=0 throughout and fields stable.
  - After the handshake, the second frame loads with its own values.
- Early `tlast` on beat 5: `frame_err` pulses once and no `hdr_valid` follows. A subsequent clean 20-beat frame is presented correctly.
- Missing `tlast` on beat 20, followed by 3 extra beats with `tlast` on the 3rd:
  - Response: `frame_err` pulses once, the extra beats are dropped, and the next clean frame is correct.
- Oscillating `tvalid` (2 low / 6 high) on the nominal frame: result identical to the nominal test, with `hdr_valid` 1 cycle after the final accepted beat.
- Assert `aresetn`=0 for 2 cycles after beat 10:
  - Response: all outputs reset, and `tready` is 0 during reset.
  - The following full frame is presented correctly, starting at word 0.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared constants and types for the block-header receive path feeding the miner core.
package miner_pkg;

  localparam int HDR_WORDS   = 20;
  localparam int IDX_VERSION = 0;
  localparam int IDX_PREV    = 1;
  localparam int IDX_MERKLE  = 9;
  localparam int IDX_TIME    = 17;
  localparam int IDX_NBITS   = 18;
  localparam int IDX_NONCE   = 19;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_HOLD,
    ST_DISCARD
  } hdr_rx_state_t;

  // Word 0 sits in the top 32 bits of the 640-bit header image.
  function automatic int word_lsb(input int idx);
    return (HDR_WORDS - 1 - idx) * 32;
  endfunction

endpackage

// File: rtl/axis_blk_header_rx.sv
// AXI4-Stream slave collecting one 80-byte block header (20 x 32-bit beats) and
// presenting it to the miner with a valid/ready handshake; bad frames are dropped.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_COLLECT | accepting header words 0..19 into the header image
// ST_HOLD    | header complete, fields frozen, stream stalled until hdr_ready
// ST_DISCARD | frame overran 20 words; drop beats until tlast
module axis_blk_header_rx
  import miner_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int LAST_CHECK           = 1
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [31:0]                     blk_version,
  output logic [255:0]                    prev_blk_header_hash,
  output logic [255:0]                    merkle_root_hash,
  output logic [31:0]                     blk_time,
  output logic [31:0]                     blk_nbits,
  output logic [31:0]                     blk_nonce,
  output logic                            hdr_valid,
  input  logic                            hdr_ready,
  output logic                            frame_err
);

  if (C_S_AXIS_TDATA_WIDTH != 32) begin : g_width_chk
    $error("axis_blk_header_rx: only a 32-bit TDATA width is supported");
  end

  localparam bit          LC        = (LAST_CHECK != 0);
  localparam logic [4:0]  LAST_WORD = 5'(IDX_NONCE);

  hdr_rx_state_t r_state;
  logic [4:0]    r_wcnt;
  logic [639:0]  r_hdr;
  logic          r_tready;
  logic          r_hdr_valid;
  logic          r_frame_err;

  logic          w_accept;
  logic [9:0]    w_word_lsb;

  assign w_accept   = s_axis_tvalid && r_tready;
  assign w_word_lsb = {LAST_WORD - r_wcnt, 5'b0};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_COLLECT;
      r_wcnt      <= '0;
      r_hdr       <= '0;
      r_tready    <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          r_tready <= 1'b1;
          if (w_accept) begin
            r_hdr[w_word_lsb +: 32] <= s_axis_tdata;
            if (r_wcnt == LAST_WORD) begin
              r_wcnt <= '0;
              if (!LC || s_axis_tlast) begin
                r_state     <= ST_HOLD;
                r_hdr_valid <= 1'b1;
                r_tready    <= 1'b0;
              end else begin
                r_state     <= ST_DISCARD;
                r_frame_err <= 1'b1;
              end
            end else if (LC && s_axis_tlast) begin
              r_wcnt      <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + 5'd1;
            end
          end
        end
        ST_HOLD: begin
          if (hdr_ready) begin
            r_state     <= ST_COLLECT;
            r_wcnt      <= '0;
            r_hdr_valid <= 1'b0;
            r_tready    <= 1'b1;
          end
        end
        ST_DISCARD: begin
          r_tready <= 1'b1;
          if (w_accept && s_axis_tlast) begin
            r_state <= ST_COLLECT;
            r_wcnt  <= '0;
          end
        end
        default: begin
          r_state  <= ST_COLLECT;
          r_wcnt   <= '0;
          r_tready <= 1'b1;
        end
      endcase
    end
  end

  assign s_axis_tready        = r_tready;
  assign hdr_valid            = r_hdr_valid;
  assign frame_err            = r_frame_err;
  assign blk_version          = r_hdr[word_lsb(IDX_VERSION) +: 32];
  assign prev_blk_header_hash = r_hdr[word_lsb(IDX_PREV) + 31 -: 256];
  assign merkle_root_hash     = r_hdr[word_lsb(IDX_MERKLE) + 31 -: 256];
  assign blk_time             = r_hdr[word_lsb(IDX_TIME) +: 32];
  assign blk_nbits            = r_hdr[word_lsb(IDX_NBITS) +: 32];
  assign blk_nonce            = r_hdr[word_lsb(IDX_NONCE) +: 32];

endmodule

// File: tb/tb_axis_blk_header_rx.sv
// Self-checking bench for axis_blk_header_rx: table of frames plus back-pressure
// and mid-frame reset sequences, with a header scoreboard checked on hdr_valid.
module tb_axis_blk_header_rx;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [31:0]  s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [31:0]  blk_version;
  logic [255:0] prev_blk_header_hash;
  logic [255:0] merkle_root_hash;
  logic [31:0]  blk_time;
  logic [31:0]  blk_nbits;
  logic [31:0]  blk_nonce;
  logic         hdr_valid;
  logic         hdr_ready = 1'b1;
  logic         frame_err;

  axis_blk_header_rx #(.C_S_AXIS_TDATA_WIDTH(32), .LAST_CHECK(1)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .blk_version          (blk_version),
    .prev_blk_header_hash (prev_blk_header_hash),
    .merkle_root_hash     (merkle_root_hash),
    .blk_time             (blk_time),
    .blk_nbits            (blk_nbits),
    .blk_nonce            (blk_nonce),
    .hdr_valid            (hdr_valid),
    .hdr_ready            (hdr_ready),
    .frame_err            (frame_err)
  );

  always #5 aclk = ~aclk;

  localparam logic [639:0] NOMINAL = {
    32'h02000000,
    256'h671D0E2F_2F1D7A8B_9C0D4E5F_6A7B8C9D_00000000_00000000_00000000_00000000,
    256'h2CD900FC_1A2B3C4D_5E6F7081_92A3B4C5_D6E7F809_1A2B3C4D_5E6F7081_45F4992E,
    32'h74749054, 32'h747B1B18, 32'h43F740C0
  };

  typedef struct {
    logic [639:0] hdr;
    int           early_at;
    bit           miss_last;
    bit           gap;
    int           exp_err;
    int           exp_hdr;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last19_cyc = -1;
  int err_cnt = 0;
  int hdr_cnt = 0;
  int vlen = 0;
  int last_len = 0;
  bit prev_v = 0;
  bit prev_e = 0;
  logic [639:0] exp_q[$];
  logic [639:0] cur_exp = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [639:0] dut_hdr();
    return {blk_version, prev_blk_header_hash, merkle_root_hash, blk_time, blk_nbits, blk_nonce};
  endfunction

  // Scoreboard monitor: pops an expected header on each hdr_valid rise.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_v = 0;
      prev_e = 0;
      vlen   = 0;
    end else begin
      if (hdr_valid && !prev_v) begin
        hdr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_hdr_valid", 256'(1), 256'(0));
          cur_exp = dut_hdr();
        end else begin
          cur_exp = exp_q.pop_front();
          chk("latency_cycle", 256'(cyc), 256'(last19_cyc));
          chk("blk_version", 256'(blk_version), 256'(cur_exp[639:608]));
          chk("prev_blk_header_hash", prev_blk_header_hash, cur_exp[607:352]);
          chk("merkle_root_hash", merkle_root_hash, cur_exp[351:96]);
          chk("blk_time", 256'(blk_time), 256'(cur_exp[95:64]));
          chk("blk_nbits", 256'(blk_nbits), 256'(cur_exp[63:32]));
          chk("blk_nonce", 256'(blk_nonce), 256'(cur_exp[31:0]));
        end
      end else if (hdr_valid) begin
        chk("hold_fields_stable", 256'(dut_hdr() !== cur_exp), 256'(0));
      end
      if (hdr_valid) chk("tready_low_in_hold", 256'(s_axis_tready), 256'(0));
      if (!hdr_valid && prev_v) last_len = vlen;
      if (hdr_valid) vlen = prev_v ? vlen + 1 : 1;
      if (frame_err) begin
        err_cnt++;
        if (prev_e) chk("frame_err_one_cycle", 256'(1), 256'(0));
      end
      prev_v = hdr_valid;
      prev_e = frame_err;
    end
  end

  task automatic send_beat(input logic [31:0] data, input bit last);
    bit acc;
    bit ok;
    ok = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      if (acc) ok = 1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!ok) chk("beat_accept_timeout", 256'(0), 256'(1));
  endtask

  task automatic send_frame(input logic [639:0] hdr, input int early_at, input bit miss_last,
                            input bit gap, input bit push);
    logic [639:0] h;
    bit last;
    h = hdr;
    if (push) exp_q.push_back(hdr);
    for (int w = 0; w < 20; w++) begin
      if (gap && w > 0 && (w % 6) == 0) begin
        repeat (2) @(posedge aclk);
        #1;
      end
      last = (early_at != 0 && w == early_at - 1) || (w == 19 && !miss_last);
      send_beat(h[639 - 32*w -: 32], last);
      if (w == 19 && push) last19_cyc = cyc;
      if (early_at != 0 && w == early_at - 1) break;
    end
    if (miss_last) begin
      for (int k = 0; k < 3; k++) send_beat($urandom, k == 2);
    end
  endtask

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h;
    for (int w = 0; w < 20; w++) h[32*w +: 32] = $urandom;
    return h;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int e0;
    int h0;
    logic [639:0] h1;
    logic [639:0] h2;

    vecs[0] = '{hdr: NOMINAL,    early_at: 0, miss_last: 0, gap: 0, exp_err: 0, exp_hdr: 1};
    vecs[1] = '{hdr: rand_hdr(), early_at: 5, miss_last: 0, gap: 0, exp_err: 1, exp_hdr: 0};
    vecs[2] = '{hdr: rand_hdr(), early_at: 0, miss_last: 0, gap: 0, exp_err: 0, exp_hdr: 1};
    vecs[3] = '{hdr: rand_hdr(), early_at: 0, miss_last: 1, gap: 0, exp_err: 1, exp_hdr: 0};
    vecs[4] = '{hdr: rand_hdr(), early_at: 0, miss_last: 0, gap: 0, exp_err: 0, exp_hdr: 1};
    vecs[5] = '{hdr: NOMINAL,    early_at: 0, miss_last: 0, gap: 1, exp_err: 0, exp_hdr: 1};

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_tready", 256'(s_axis_tready), 256'(0));
    chk("reset_hdr_valid", 256'(hdr_valid), 256'(0));
    chk("reset_frame_err", 256'(frame_err), 256'(0));
    chk("reset_fields_zero", 256'(|dut_hdr()), 256'(0));
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_before_first_clock", 256'(s_axis_tready), 256'(0));
    @(negedge aclk);
    chk("tready_after_first_clock", 256'(s_axis_tready), 256'(1));
    @(posedge aclk);
    #1;

    for (int i = 0; i < 6; i++) begin
      e0 = err_cnt;
      h0 = hdr_cnt;
      last_len = 0;
      send_frame(vecs[i].hdr, vecs[i].early_at, vecs[i].miss_last, vecs[i].gap,
                 vecs[i].exp_hdr != 0);
      repeat (6) @(posedge aclk);
      #1;
      chk($sformatf("vec%0d_frame_err_count", i), 256'(err_cnt - e0), 256'(vecs[i].exp_err));
      chk($sformatf("vec%0d_hdr_count", i), 256'(hdr_cnt - h0), 256'(vecs[i].exp_hdr));
      if (vecs[i].exp_hdr != 0)
        chk($sformatf("vec%0d_hdr_valid_cycles", i), 256'(last_len), 256'(1));
    end

    // Back-pressure: miner holds off for 10 cycles while a second frame waits.
    h1 = rand_hdr();
    h2 = rand_hdr();
    h0 = hdr_cnt;
    e0 = err_cnt;
    hdr_ready = 1'b0;
    fork
      begin
        send_frame(h1, 0, 0, 0, 1);
        send_frame(h2, 0, 0, 0, 1);
      end
      begin
        bit seen;
        seen = 0;
        for (int t = 0; t < 300 && !seen; t++) begin
          @(negedge aclk);
          if (hdr_valid) seen = 1;
        end
        if (!seen) chk("bp_hdr_valid_timeout", 256'(0), 256'(1));
        repeat (10) @(negedge aclk);
        chk("bp_still_valid", 256'(hdr_valid), 256'(1));
        hdr_ready = 1'b1;
        @(negedge aclk);
        chk("bp_release_valid_low", 256'(hdr_valid), 256'(0));
        chk("bp_release_tready_high", 256'(s_axis_tready), 256'(1));
      end
    join
    repeat (6) @(posedge aclk);
    #1;
    chk("bp_hdr_count", 256'(hdr_cnt - h0), 256'(2));
    chk("bp_frame_err_count", 256'(err_cnt - e0), 256'(0));

    // Reset after beat 10 drops the partial frame.
    h1 = rand_hdr();
    for (int w = 0; w < 10; w++) send_beat(h1[639 - 32*w -: 32], 1'b0);
    aresetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      chk("midreset_tready", 256'(s_axis_tready), 256'(0));
      chk("midreset_outputs", 256'({hdr_valid, frame_err, |dut_hdr()}), 256'(0));
      @(posedge aclk);
      #1;
    end
    aresetn = 1'b1;
    h0 = hdr_cnt;
    e0 = err_cnt;
    h2 = rand_hdr();
    send_frame(h2, 0, 0, 0, 1);
    repeat (6) @(posedge aclk);
    #1;
    chk("post_reset_hdr_count", 256'(hdr_cnt - h0), 256'(1));
    chk("post_reset_frame_err_count", 256'(err_cnt - e0), 256'(0));
    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
